// File: rtl/wallace_reduce_pipe_if.sv
// Partial-product array in, product out: valid/ready bundle for wallace_reduce_pipe.
// slave is the reducer's view, master is the producer/consumer side.
interface wallace_reduce_pipe_if #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned TAG_W = 4
);
  logic [DIM-1:0]   pp_prods [DIM-1:0];
  logic             in_valid;
  logic [TAG_W-1:0] in_tag;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [2*DIM-1:0] product;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  pp_prods, in_valid, in_tag, out_ready,
    output in_ready, out_valid, product, out_tag
  );

  modport master (
    output pp_prods, in_valid, in_tag, out_ready,
    input  in_ready, out_valid, product, out_tag
  );
endinterface

// File: rtl/wallace_reduce_pipe.sv
// Three-stage Wallace-tree reducer: capture, 3:2 carry-save reduction, carry-propagate add.
// Optional WALLACE_PROD_CNT_EN adds a 16-bit count of delivered products (prod_count).
module wallace_reduce_pipe #(
  parameter int unsigned DIM   = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  wallace_reduce_pipe_if.slave bus
`ifdef WALLACE_PROD_CNT_EN
  ,
  output logic [15:0]          prod_count
`endif
);
  localparam int unsigned PW = 2 * DIM;

  logic             s1_v_q, s1_v_d;
  logic [DIM-1:0]   s1_pp_q [DIM-1:0];
  logic [DIM-1:0]   s1_pp_d [DIM-1:0];
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic             s2_v_q, s2_v_d;
  logic [PW-1:0]    s2_sum_q, s2_sum_d, s2_carry_q, s2_carry_d;
  logic [TAG_W-1:0] s2_tag_q, s2_tag_d;
  logic             s3_v_q, s3_v_d;
  logic [PW-1:0]    product_q, product_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             adv1, adv2, adv3;
  logic [PW-1:0]    red_sum, red_carry;

  // Ready ripples back from out_ready so that bubbles in S1/S2 are always filled.
  assign adv3 = !s3_v_q || bus.out_ready;
  assign adv2 = !s2_v_q || adv3;
  assign adv1 = !s1_v_q || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s3_v_q;
  assign bus.product   = product_q;
  assign bus.out_tag   = out_tag_q;

  // Full-adder layers over groups of three rows; leftover rows pass to the next layer.
  // Zero-padded operand bits turn the upper full adders into half adders.
  always_comb begin
    logic [PW-1:0] cur [DIM+2];
    logic [PW-1:0] nxt [DIM+2];
    int            n;
    int            m;
    for (int r = 0; r < DIM + 2; r++) cur[r] = '0;
    for (int r = 0; r < DIM; r++) cur[r] = PW'(s1_pp_q[r]) << r;
    nxt = cur;
    n   = DIM;
    m   = 0;
    for (int l = 0; l < DIM; l++) begin
      if (n > 2) begin
        m = 0;
        for (int r = 0; r < DIM + 2; r++) nxt[r] = '0;
        for (int i = 0; i < DIM; i += 3) begin
          if (i + 2 < n) begin
            nxt[m]     = cur[i] ^ cur[i+1] ^ cur[i+2];
            nxt[m+1]   = ((cur[i] & cur[i+1]) | (cur[i] & cur[i+2]) | (cur[i+1] & cur[i+2])) << 1;
            m          = m + 2;
          end else if (i < n) begin
            nxt[m]     = cur[i];
            nxt[m+1]   = cur[i+1];
            m          = m + (n - i);
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    red_sum   = cur[0];
    red_carry = cur[1];
  end

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_pp_d    = s1_pp_q;
    s1_tag_d   = s1_tag_q;
    s2_v_d     = s2_v_q;
    s2_sum_d   = s2_sum_q;
    s2_carry_d = s2_carry_q;
    s2_tag_d   = s2_tag_q;
    s3_v_d     = s3_v_q;
    product_d  = product_q;
    out_tag_d  = out_tag_q;
    if (adv1) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_pp_d  = bus.pp_prods;
        s1_tag_d = bus.in_tag;
      end
    end
    if (adv2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sum_d   = red_sum;
        s2_carry_d = red_carry;
        s2_tag_d   = s1_tag_q;
      end
    end
    if (adv3) begin
      s3_v_d = s2_v_q;
      if (s2_v_q) begin
        product_d = s2_sum_q + s2_carry_q;
        out_tag_d = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_v_q     <= 1'b0;
      for (int r = 0; r < DIM; r++) s1_pp_q[r] <= '0;
      s1_tag_q   <= '0;
      s2_v_q     <= 1'b0;
      s2_sum_q   <= '0;
      s2_carry_q <= '0;
      s2_tag_q   <= '0;
      s3_v_q     <= 1'b0;
      product_q  <= '0;
      out_tag_q  <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_pp_q    <= s1_pp_d;
      s1_tag_q   <= s1_tag_d;
      s2_v_q     <= s2_v_d;
      s2_sum_q   <= s2_sum_d;
      s2_carry_q <= s2_carry_d;
      s2_tag_q   <= s2_tag_d;
      s3_v_q     <= s3_v_d;
      product_q  <= product_d;
      out_tag_q  <= out_tag_d;
    end
  end

`ifdef WALLACE_PROD_CNT_EN
  logic [15:0] prod_count_q, prod_count_d;

  always_comb begin
    prod_count_d = prod_count_q;
    if (s3_v_q && bus.out_ready) prod_count_d = prod_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prod_count_q <= '0;
    else        prod_count_q <= prod_count_d;
  end

  assign prod_count = prod_count_q;
`endif
endmodule

// File: tb/tb_wallace_reduce_pipe.sv
// Scoreboard bench for wallace_reduce_pipe: the reference sums weighted rows with plain arithmetic.
module tb_wallace_reduce_pipe;
  localparam int unsigned DIM   = 8;
  localparam int unsigned TAG_W = 4;

  typedef struct {
    logic [2*DIM-1:0] p;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic clk;
  logic n_rst;
  int   total;
  int   bad;
  exp_t sb[$];
  int   hs_cnt;

  wallace_reduce_pipe_if #(.DIM(DIM), .TAG_W(TAG_W)) bus ();

`ifdef WALLACE_PROD_CNT_EN
  logic [15:0] prod_count;
`endif

  wallace_reduce_pipe #(.DIM(DIM), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.slave)
`ifdef WALLACE_PROD_CNT_EN
    ,
    .prod_count(prod_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: push on input handshake, pop/compare on output handshake, check stall stability.
  logic             held_v;
  logic [2*DIM-1:0] held_p;
  logic [TAG_W-1:0] held_t;

  always @(negedge clk) begin
    if (!n_rst) begin
      sb.delete();
      held_v = 1'b0;
      hs_cnt = 0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_product", 32'(bus.product), 32'(held_p));
        chk("stall_tag", 32'(bus.out_tag), 32'(held_t));
      end
      held_v = bus.out_valid && !bus.out_ready;
      held_p = bus.product;
      held_t = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
        exp_t e;
        longint s;
        s = 0;
        for (int r = 0; r < DIM; r++) s += longint'(bus.pp_prods[r]) * (longint'(1) << r);
        e.p = s[2*DIM-1:0];
        e.t = bus.in_tag;
        sb.push_back(e);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(bus.product), 32'hdead);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", 32'(bus.product), 32'(e.p));
          chk("out_tag", 32'(bus.out_tag), 32'(e.t));
        end
      end
    end
  end

  task automatic set_ab(input logic [DIM-1:0] a, input logic [DIM-1:0] b, input int tag);
    for (int r = 0; r < DIM; r++) bus.pp_prods[r] = b[r] ? a : '0;
    bus.in_tag = TAG_W'(tag);
  endtask

  task automatic set_rand();
    if ($urandom_range(0, 1) == 0) begin
      set_ab(DIM'($urandom), DIM'($urandom), int'($urandom));
    end else begin
      for (int r = 0; r < DIM; r++) bus.pp_prods[r] = DIM'($urandom);
      bus.in_tag = TAG_W'($urandom);
    end
  endtask

  // Present the current inputs until accepted (bounded), then drop in_valid.
  task automatic send();
    int n;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(n < 200), 32'd1);
  endtask

  initial begin
    int lat;
    int acc;
    logic ir;
    total = 0;
    bad = 0;
    hs_cnt = 0;
    n_rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_tag = '0;
    for (int r = 0; r < DIM; r++) bus.pp_prods[r] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_product", 32'(bus.product), 32'd0);
    chk("rst_out_tag", 32'(bus.out_tag), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Single product, latency
    bus.out_ready = 1'b1;
    set_ab(8'hFF, 8'hFF, 5);
    send();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 10);
    chk("latency", 32'(lat), 32'd3);
    chk("ff_x_ff", 32'(bus.product), 32'hFE01);
    chk("ff_tag", 32'(bus.out_tag), 32'h5);
    wait_drain();

    // Back-to-back stream
    set_ab(8'd3, 8'd5, 0);     send();
    set_ab(8'd0, 8'hAA, 1);    send();
    set_ab(8'h80, 8'h80, 2);   send();
    set_ab(8'hFF, 8'h01, 3);   send();
    wait_drain();

    // Stall: one item parked in S3, then three more offered against out_ready=0
    bus.out_ready = 1'b0;
    set_ab(8'd7, 8'd9, 6);
    send();
    repeat (4) @(posedge clk);
    #1;
    acc = 1;
    for (int k = 0; k < 3; k++) begin
      set_ab(DIM'(k + 10), DIM'(k + 20), k + 7);
      bus.in_valid = 1'b1;
      @(negedge clk);
      ir = bus.in_ready;
      chk("stall_in_ready", 32'(ir), (k < 2) ? 32'd1 : 32'd0);
      if (ir) acc++;
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", 32'(acc), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    send();
    wait_drain();

    // Reset with three products in flight
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ab(DIM'($urandom), DIM'($urandom), k);
      send();
    end
    repeat (2) @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_product", 32'(bus.product), 32'd0);
    chk("mid_rst_tag", 32'(bus.out_tag), 32'd0);
    sb.delete();
    @(posedge clk);
    #3;
    n_rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 32'(bus.out_valid), 32'd0);
    end

    // Random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      logic accd;
      @(negedge clk);
      accd = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (accd || !bus.in_valid) begin
        if ($urandom_range(0, 3) != 0) begin
          set_rand();
          bus.in_valid = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    if (bus.in_valid && !bus.in_ready) begin
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send();
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b1;
    wait_drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);

`ifdef WALLACE_PROD_CNT_EN
    chk("prod_count", 32'(prod_count), 32'(hs_cnt[15:0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
